// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundles decode, execute-kill, write-back and
// scoreboard-output signals for the register-file scoreboard.
//   slave  : scoreboard side (consumes decode/execute/write-back, drives outputs)
//   master : pipeline side (drives decode/execute/write-back, reads outputs)
// Optional macro SCOREBOARD_PERF_EN adds two 32-bit performance counters.
interface regfile_scoreboard_if;
    logic        decode_i_valid;
    logic [4:0]  decode_i_rs1;
    logic        decode_i_rs1_used;
    logic [11:0] decode_i_rs2;
    logic        decode_i_rs2_used;
    logic [4:0]  decode_i_rd;
    logic        decode_i_rd_wen;
    logic        decode_i_is_csr;
    logic        execute_i_kill;
    logic [4:0]  execute_i_kill_rd;
    logic        execute_i_kill_rd_wen;
    logic        write_back_i_wb_reg_wen;
    logic [4:0]  write_back_i_wb_rd;
    logic [2:0]  write_back_i_wb_csr_sel;
    logic        scoreboard_o_stall;
    logic        scoreboard_o_issue;
    logic        scoreboard_o_idle;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] scoreboard_o_stall_cycles;
    logic [31:0] scoreboard_o_csr_drains;

    modport slave (
        input  decode_i_valid, decode_i_rs1, decode_i_rs1_used, decode_i_rs2,
               decode_i_rs2_used, decode_i_rd, decode_i_rd_wen, decode_i_is_csr,
               execute_i_kill, execute_i_kill_rd, execute_i_kill_rd_wen,
               write_back_i_wb_reg_wen, write_back_i_wb_rd, write_back_i_wb_csr_sel,
        output scoreboard_o_stall, scoreboard_o_issue, scoreboard_o_idle,
               scoreboard_o_stall_cycles, scoreboard_o_csr_drains
    );
    modport master (
        output decode_i_valid, decode_i_rs1, decode_i_rs1_used, decode_i_rs2,
               decode_i_rs2_used, decode_i_rd, decode_i_rd_wen, decode_i_is_csr,
               execute_i_kill, execute_i_kill_rd, execute_i_kill_rd_wen,
               write_back_i_wb_reg_wen, write_back_i_wb_rd, write_back_i_wb_csr_sel,
        input  scoreboard_o_stall, scoreboard_o_issue, scoreboard_o_idle,
               scoreboard_o_stall_cycles, scoreboard_o_csr_drains
    );
`else
    modport slave (
        input  decode_i_valid, decode_i_rs1, decode_i_rs1_used, decode_i_rs2,
               decode_i_rs2_used, decode_i_rd, decode_i_rd_wen, decode_i_is_csr,
               execute_i_kill, execute_i_kill_rd, execute_i_kill_rd_wen,
               write_back_i_wb_reg_wen, write_back_i_wb_rd, write_back_i_wb_csr_sel,
        output scoreboard_o_stall, scoreboard_o_issue, scoreboard_o_idle
    );
    modport master (
        output decode_i_valid, decode_i_rs1, decode_i_rs1_used, decode_i_rs2,
               decode_i_rs2_used, decode_i_rd, decode_i_rd_wen, decode_i_is_csr,
               execute_i_kill, execute_i_kill_rd, execute_i_kill_rd_wen,
               write_back_i_wb_reg_wen, write_back_i_wb_rd, write_back_i_wb_csr_sel,
        input  scoreboard_o_stall, scoreboard_o_issue, scoreboard_o_idle
    );
`endif
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: in-order issue controller for the shared GPR/CSR file.
// Tracks in-flight GPR writes with a saturating counter per register and
// stalls decode on RAW/WAW hazards; serializes CSR-class instructions by
// draining the pipeline before issue and holding younger instructions until
// the CSR writeback (or a squash of the CSR).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   sb       : regfile_scoreboard_if.slave (decode/execute/write-back in,
//              stall/issue/idle out)
// Optional macro SCOREBOARD_PERF_EN: adds stall_cycles / csr_drains counters.
module regfile_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, DRAIN, CSR_WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic             any_pend;
    logic             hazard;
    logic             stall;
    logic             issue;

    // Counters are read pre-update, so a retire releases the hazard one
    // cycle later.
    always_comb begin
        any_pend = 1'b0;
        for (int i = 1; i < 32; i++)
            if (cnt_q[i] != '0) any_pend = 1'b1;
    end

    assign hazard = sb.decode_i_valid &&
        ((sb.decode_i_rs1_used && cnt_q[sb.decode_i_rs1] != '0) ||
         (sb.decode_i_rs2_used && !sb.decode_i_is_csr && cnt_q[sb.decode_i_rs2[4:0]] != '0) ||
         (sb.decode_i_rd_wen && cnt_q[sb.decode_i_rd] == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sb.decode_i_valid && sb.decode_i_is_csr) begin
                    if (any_pend) begin
                        stall   = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = CSR_WAIT;
                    end
                end else begin
                    stall = hazard;
                end
            end
            DRAIN: begin
                // Decode dropping the CSR means there is nothing left to drain for.
                if (!sb.decode_i_valid) state_d = IDLE;
                else if (any_pend)      stall   = 1'b1;
                else                    state_d = CSR_WAIT;
            end
            CSR_WAIT: begin
                stall = sb.decode_i_valid;
                if (sb.execute_i_kill || sb.write_back_i_wb_csr_sel != 3'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue = sb.decode_i_valid && !stall;

    // Net per-register change: at most one increment and two decrements;
    // the result floors at zero.
    always_comb begin
        logic [CNT_W:0] sum;
        logic [CNT_W:0] ndec;
        for (int i = 0; i < 32; i++) begin
            sum  = {1'b0, cnt_q[i]};
            ndec = '0;
            if (issue && sb.decode_i_rd_wen && sb.decode_i_rd == 5'(i)) sum = sum + 1'b1;
            if (sb.write_back_i_wb_reg_wen && sb.write_back_i_wb_rd == 5'(i)) ndec = ndec + 1'b1;
            if (sb.execute_i_kill && sb.execute_i_kill_rd_wen && sb.execute_i_kill_rd == 5'(i))
                ndec = ndec + 1'b1;
            if (i == 0 || sum < ndec) cnt_d[i] = '0;
            else                      cnt_d[i] = CNT_W'(sum - ndec);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

    assign sb.scoreboard_o_stall = stall;
    assign sb.scoreboard_o_issue = issue;
    assign sb.scoreboard_o_idle  = !any_pend && state_q == IDLE;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] csr_drains_q, csr_drains_d;

    assign stall_cycles_d = stall_cycles_q + {31'd0, stall};
    assign csr_drains_d   = csr_drains_q + {31'd0, (state_q == IDLE && state_d == DRAIN)};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            csr_drains_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            csr_drains_q   <= csr_drains_d;
        end
    end

    assign sb.scoreboard_o_stall_cycles = stall_cycles_q;
    assign sb.scoreboard_o_csr_drains   = csr_drains_q;
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with an expectation queue; each
// driven cycle pushes its expected stall/issue/idle, a negedge monitor pops
// and compares.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    typedef struct {
        string tag;
        logic  stall;
        logic  issue;
        logic  idle;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_scoreboard_if sb_if();

    regfile_scoreboard #(.CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".stall"}, {31'd0, sb_if.scoreboard_o_stall}, {31'd0, e.stall});
            chk({e.tag, ".issue"}, {31'd0, sb_if.scoreboard_o_issue}, {31'd0, e.issue});
            chk({e.tag, ".idle"},  {31'd0, sb_if.scoreboard_o_idle},  {31'd0, e.idle});
        end
    end

    task automatic clr();
        sb_if.decode_i_valid          = 1'b0;
        sb_if.decode_i_rs1            = '0;
        sb_if.decode_i_rs1_used       = 1'b0;
        sb_if.decode_i_rs2            = '0;
        sb_if.decode_i_rs2_used       = 1'b0;
        sb_if.decode_i_rd             = '0;
        sb_if.decode_i_rd_wen         = 1'b0;
        sb_if.decode_i_is_csr         = 1'b0;
        sb_if.execute_i_kill          = 1'b0;
        sb_if.execute_i_kill_rd       = '0;
        sb_if.execute_i_kill_rd_wen   = 1'b0;
        sb_if.write_back_i_wb_reg_wen = 1'b0;
        sb_if.write_back_i_wb_rd      = '0;
        sb_if.write_back_i_wb_csr_sel = '0;
    endtask

    // Push the expectation for the currently driven inputs, let the monitor
    // sample, cross the clock edge and return inputs to idle.
    task automatic cyc(input string tag, input logic es, input logic ei, input logic eid);
        exp_t e;
        e.tag = tag; e.stall = es; e.issue = ei; e.idle = eid;
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic dec(input logic [4:0] rs1, input logic u1, input logic [11:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic wen, input logic csr);
        sb_if.decode_i_valid    = 1'b1;
        sb_if.decode_i_rs1      = rs1;
        sb_if.decode_i_rs1_used = u1;
        sb_if.decode_i_rs2      = rs2;
        sb_if.decode_i_rs2_used = u2;
        sb_if.decode_i_rd       = rd;
        sb_if.decode_i_rd_wen   = wen;
        sb_if.decode_i_is_csr   = csr;
    endtask

    task automatic wb(input logic [4:0] rd);
        sb_if.write_back_i_wb_reg_wen = 1'b1;
        sb_if.write_back_i_wb_rd      = rd;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc("reset", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // RAW on x5, released the cycle after its retire
        dec(0, 0, 0, 0, 5, 1, 0);  cyc("raw.wr",     0, 1, 1);
        dec(5, 1, 0, 0, 0, 0, 0);  cyc("raw.hold",   1, 0, 0);
        dec(5, 1, 0, 0, 0, 0, 0); wb(5); cyc("raw.retire", 1, 0, 0);
        dec(5, 1, 0, 0, 0, 0, 0);  cyc("raw.go",     0, 1, 1);
        cyc("raw.quiet", 0, 0, 1);

        // x0 is never tracked
        for (int i = 0; i < 4; i++) begin
            dec(0, 0, 0, 0, 0, 1, 0); cyc($sformatf("x0.wr%0d", i), 0, 1, 1);
        end
        dec(0, 1, 0, 0, 0, 0, 0);  cyc("x0.rd", 0, 1, 1);

        // counter saturation: 4th writer to x7 waits
        dec(0, 0, 0, 0, 7, 1, 0);  cyc("sat.w1", 0, 1, 1);
        dec(0, 0, 0, 0, 7, 1, 0);  cyc("sat.w2", 0, 1, 0);
        dec(0, 0, 0, 0, 7, 1, 0);  cyc("sat.w3", 0, 1, 0);
        dec(0, 0, 0, 0, 7, 1, 0);  cyc("sat.w4", 1, 0, 0);
        dec(0, 0, 0, 0, 7, 1, 0); wb(7); cyc("sat.ret", 1, 0, 0);
        dec(0, 0, 0, 0, 7, 1, 0);  cyc("sat.w4go", 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            wb(7); cyc($sformatf("sat.drain%0d", i), 0, 0, 0);
        end
        cyc("sat.empty", 0, 0, 1);

        // same-cycle inc + dec leaves x9 at 1
        dec(0, 0, 0, 0, 9, 1, 0);  cyc("same.w1", 0, 1, 1);
        dec(0, 0, 0, 0, 9, 1, 0); wb(9); cyc("same.w2", 0, 1, 0);
        dec(9, 1, 0, 0, 0, 0, 0); wb(9); cyc("same.hold", 1, 0, 0);
        dec(9, 1, 0, 0, 0, 0, 0);  cyc("same.go", 0, 1, 1);

        // rs2 hazard uses only the low five bits
        dec(0, 0, 0, 0, 6, 1, 0);  cyc("rs2.wr", 0, 1, 1);
        dec(0, 0, 12'h7E6, 1, 0, 0, 0); cyc("rs2.hold", 1, 0, 0);
        dec(0, 0, 12'h7E6, 1, 0, 0, 0); wb(6); cyc("rs2.ret", 1, 0, 0);
        dec(0, 0, 12'h7E6, 1, 0, 0, 0); cyc("rs2.go", 0, 1, 1);

        // CSR drain / wait sequence
        dec(0, 0, 0, 0, 3, 1, 0);  cyc("csr.x3", 0, 1, 1);
        dec(4, 1, 12'h300, 0, 10, 1, 1); cyc("csr.drain0", 1, 0, 0);
        dec(4, 1, 12'h300, 0, 10, 1, 1); cyc("csr.drain1", 1, 0, 0);
        dec(4, 1, 12'h300, 0, 10, 1, 1); wb(3); cyc("csr.drain2", 1, 0, 0);
        dec(4, 1, 12'h300, 0, 10, 1, 1); cyc("csr.issue", 0, 1, 0);
        dec(0, 0, 0, 0, 11, 1, 0); cyc("csr.wait", 1, 0, 0);
        dec(0, 0, 0, 0, 11, 1, 0); wb(10); sb_if.write_back_i_wb_csr_sel = 3'b001;
        cyc("csr.done", 1, 0, 0);
        dec(0, 0, 0, 0, 11, 1, 0); cyc("csr.next", 0, 1, 1);
        wb(11); cyc("csr.x11ret", 0, 0, 0);
        cyc("csr.quiet", 0, 0, 1);

        // CSR with nothing pending issues at once; a kill releases CSR_WAIT
        dec(0, 0, 12'h341, 0, 0, 0, 1); cyc("kcsr.issue", 0, 1, 1);
        cyc("kcsr.wait", 0, 0, 0);
        sb_if.execute_i_kill = 1'b1; cyc("kcsr.kill", 0, 0, 0);
        cyc("kcsr.idle", 0, 0, 1);

        // kill of an issued writer returns its counter to 0
        dec(0, 0, 0, 0, 12, 1, 0); cyc("kill.wr", 0, 1, 1);
        sb_if.execute_i_kill = 1'b1; sb_if.execute_i_kill_rd = 5'd12;
        sb_if.execute_i_kill_rd_wen = 1'b1; cyc("kill.sq", 0, 0, 0);
        dec(12, 1, 0, 0, 0, 0, 0); cyc("kill.rd", 0, 1, 1);

        // reset in DRAIN
        dec(0, 0, 0, 0, 3, 1, 0);  cyc("rst.x3", 0, 1, 1);
        dec(0, 0, 12'h300, 0, 0, 0, 1); cyc("rst.drain", 1, 0, 0);
        dec(0, 0, 12'h300, 0, 0, 0, 1); rst = 1'b1; cyc("rst.assert", 1, 0, 0);
        rst = 1'b0;
        cyc("rst.after", 0, 0, 1);
`ifdef SCOREBOARD_PERF_EN
        chk("perf.stall_cycles", sb_if.scoreboard_o_stall_cycles, 32'd0);
        chk("perf.csr_drains",   sb_if.scoreboard_o_csr_drains,   32'd0);
`endif

        chk("queue.empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- In-order issue controller for the pipelined CPU's shared GPR/CSR register file. Sits beside decode.
- Tracks in-flight GPR writes per register and stalls decode on RAW/WAW hazards against pending writes.
- Serializes CSR/ecall instructions: they issue only when the pipeline has drained, and younger instructions are held until their writeback completes.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- decode_i_valid  input  1  instruction present in decode
- decode_i_rs1  input  5  source 1 index
- decode_i_rs1_used  input  1  rs1 is read
- decode_i_rs2  input  12  source 2 index / CSR address; hazard uses [4:0]
- decode_i_rs2_used  input  1  rs2 is read as a GPR
- decode_i_rd  input  5  destination index
- decode_i_rd_wen  input  1  instruction writes rd
- decode_i_is_csr  input  1  csrrw/csrrs/ecall/mret class
- execute_i_kill  input  1  instruction leaving decode→execute is squashed this cycle
- execute_i_kill_rd  input  5  rd of squashed instruction
- execute_i_kill_rd_wen  input  1  squashed instruction had issued with rd write
- write_back_i_wb_reg_wen  input  1  GPR write retiring
- write_back_i_wb_rd  input  5  retiring rd
- write_back_i_wb_csr_sel  input  3  nonzero = CSR op retiring
- scoreboard_o_stall  output  1  hold decode, inject bubble
- scoreboard_o_issue  output  1  decode instruction issues this cycle
- scoreboard_o_idle  output  1  no pending writes, FSM in IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge): all counters 0, FSM=IDLE, stall=0, issue=0, idle=1. Reset mid-CSR-wait returns to IDLE and drops the stall next cycle.
- Counters: cnt[1..31], CNT_W bits each. cnt[0] is constant 0; x0 is never tracked, never hazards.
- Hazard (combinational): decode_i_valid && ((rs1_used && cnt[rs1]!=0) || (rs2_used && !is_csr && cnt[rs2[4:0]]!=0) || (rd_wen && cnt[rd]==max)).
- Same-cycle retire does not clear the hazard. The counter is read pre-update: a one-cycle-late release is acceptable and required.
- issue = decode_i_valid && !stall. Outputs are combinational from state and inputs; latency 0.
- Counter update each cycle:
  - +1 on cnt[rd] when issue && rd_wen && rd!=0.
  - -1 on write_back rd when wb_reg_wen && rd!=0.
  - -1 on kill rd when execute_i_kill && kill_rd_wen && rd!=0.
  - Net change summed. Inc+dec on the same reg = unchanged; inc+2 decs = -1.
  - Underflow is never driven. If it occurs, the counter saturates at 0.
- FSM:
  - IDLE: CSR in decode with any cnt!=0 → stall, go DRAIN. CSR in decode with all zero → issue, go CSR_WAIT.
  - DRAIN: stall=1. When all cnt==0 → issue the CSR that cycle, go CSR_WAIT.
  - CSR_WAIT: stall=1 for every decode instruction. When wb_csr_sel!=0 → go IDLE; the next instruction may issue in the following cycle.
  - execute_i_kill while in CSR_WAIT (CSR squashed) → go IDLE.
- A CSR instruction with rd_wen increments cnt[rd] like any writer. Its GPR write-back decrements it normally.
- decode_i_valid=0 → stall=0, issue=0, FSM does not leave IDLE.
- idle = (all cnt==0) && FSM==IDLE.

Optional Feature:
- Macro SCOREBOARD_PERF_EN.
- Defined: adds outputs scoreboard_o_stall_cycles and scoreboard_o_csr_drains (32 bits each, reset 0).
  - stall_cycles increments on each cycle with stall=1.
  - csr_drains increments on each IDLE→DRAIN transition.
  - Both wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Issue add rd=5; next cycle decode reads rs1=5 → stall=1 until the cycle after wb_rd=5 retires; then issue=1 and cnt[5]=0.
- Issue writes to x0 ×4, then read rs1=0 → never stalls; idle stays 1.
- CNT_W=2, three writes to x7 issued back-to-back with no retire → 4th writer to x7 stalls (cnt=3). One retire → issues next cycle.
- Same cycle: issue rd=9 and wb_rd=9 retire with cnt[9]=1 → cnt[9] stays 1.
- csrrw with cnt[3]=1 pending → DRAIN with stall=1. x3 retires → CSR issues, CSR_WAIT. wb_csr_sel=3'b001 → IDLE; next add issues one cycle later.
- Kill issued rd=12 (kill_rd_wen=1) → cnt[12] returns to 0. Kill in CSR_WAIT → FSM IDLE next cycle.
- rst asserted during DRAIN → stall=0, idle=1 next cycle. With SCOREBOARD_PERF_EN, both counters read 0.
